// File: rtl/maxpool2x2_stream.sv
// ----------------------------------------------------------------------------
// maxpool2x2_stream
//
// Streaming 2x2 / stride-2 max-pooling stage. Input pixels arrive one per
// accepted beat in raster order (row 0 col 0..IN_COLS-1, then row 1, ...).
// The pooled (IN_ROWS/2)x(IN_COLS/2) map is produced with a single
// half-width line buffer, so a full frame is never stored.
//
// Handshake (both sides): a beat transfers on a rising clock edge where
// valid & ready are both high. A producer holds valid and its payload until
// the transfer happens. in_ready is combinational: the stage accepts whenever
// its single output register is empty or is being drained this same cycle,
// and never while clr is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear (counters, out_valid, out_last to 0)
//   in_valid   input pixel valid
//   in_ready   stage can accept an input pixel this cycle
//   in_data    signed input pixel
//   out_valid  pooled pixel valid
//   out_ready  consumer accepts the pooled pixel
//   out_data   signed maximum of the 2x2 block
//   out_row    pooled row index 0..IN_ROWS/2-1
//   out_col    pooled column index 0..IN_COLS/2-1
//   out_last   final pooled pixel of the frame (qualified by out_valid)
// ----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DATA_W  = 16,
    parameter int IN_COLS = 26,
    parameter int IN_ROWS = 26,
    parameter int CNT_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [CNT_W-1:0]  out_row,
    output logic        [CNT_W-1:0]  out_col,
    output logic                     out_last
);

    localparam int HALF = IN_COLS / 2;
    // Index width of the line buffer; at least one bit so the slice below is legal.
    localparam int K_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(IN_COLS - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(IN_ROWS - 1);

    if ((IN_COLS < 2) || ((IN_COLS % 2) != 0)) begin : g_bad_cols
        $error("maxpool2x2_stream: IN_COLS must be even and >= 2");
    end
    if ((IN_ROWS < 2) || ((IN_ROWS % 2) != 0)) begin : g_bad_rows
        $error("maxpool2x2_stream: IN_ROWS must be even and >= 2");
    end
    if ((IN_COLS > (1 << CNT_W)) || (IN_ROWS > (1 << CNT_W)) || (CNT_W <= K_W)) begin : g_bad_cnt
        $error("maxpool2x2_stream: CNT_W too small for IN_COLS/IN_ROWS");
    end

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic        [CNT_W-1:0]  c;
    logic        [CNT_W-1:0]  r;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] lbuf [0:HALF-1];
    logic        [K_W-1:0]    k;
    logic                     accept;
    logic                     col_last;
    logic                     row_last;

    // Output register is free if empty or draining this cycle; clr blocks input
    // so a clear always wins over a same-cycle beat.
    assign in_ready = !(out_valid && !out_ready) && !clr;
    assign accept   = in_valid && in_ready;
    assign k        = c[K_W:1];
    assign col_last = (c == C_LAST);
    assign row_last = (r == R_LAST);

    // Line buffer holds the pairwise max of each column pair of the even row.
    // Not reset: every entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && !r[0] && c[0]) begin
            lbuf[k] <= smax(hold, in_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c         <= '0;
            r         <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (clr) begin
            c         <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                // Raster position counters; the frame wraps with no idle cycle.
                if (col_last) begin
                    c <= '0;
                    r <= row_last ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end

                unique case ({r[0], c[0]})
                    2'b00: hold <= in_data;
                    2'b01: ; // line buffer written in its own process
                    2'b10: hold <= smax(lbuf[k], in_data);
                    2'b11: begin
                        // A load here overrides a same-cycle drain above.
                        out_data  <= smax(hold, in_data);
                        out_row   <= r >> 1;
                        out_col   <= CNT_W'(k);
                        out_last  <= row_last && col_last;
                        out_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// ----------------------------------------------------------------------------
// tb_maxpool2x2_stream
//
// Two instances: a 4x4 frame (directed ramp, signed, backpressure, clr) and
// the default 26x26 frame (random back-to-back frames, mid-frame reset).
// Expected pooled pixels come from a frame-level reference model that takes
// the max of each 2x2 block of a stored input frame.
// ----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

  localparam int DW = 16;
  localparam int CW = 10;
  localparam int EW = 1 + CW + CW + DW;  // {last,row,col,data}
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4x4 instance
  logic                 clr4 = 1'b0, in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_last4;
  logic signed [DW-1:0] in_data4 = '0, out_data4;
  logic [CW-1:0]        out_row4, out_col4;
  // 26x26 instance
  logic                 clr26 = 1'b0, in_valid26 = 1'b0, in_ready26, out_valid26, out_ready26 = 1'b0, out_last26;
  logic signed [DW-1:0] in_data26 = '0, out_data26;
  logic [CW-1:0]        out_row26, out_col26;

  logic [EW-1:0] exp4_q[$];
  logic [EW-1:0] exp26_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int pix[676];
  bit prev_hold[2];
  logic [EW-1:0] prev_f[2];

  always #5 clk = ~clk;

  maxpool2x2_stream #(.DATA_W(DW), .IN_COLS(4), .IN_ROWS(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst(rst), .clr(clr4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_row(out_row4), .out_col(out_col4), .out_last(out_last4)
  );

  maxpool2x2_stream #(.DATA_W(DW), .IN_COLS(26), .IN_ROWS(26), .CNT_W(CW)) dut26 (
    .clk(clk), .rst(rst), .clr(clr26), .in_valid(in_valid26), .in_ready(in_ready26),
    .in_data(in_data26), .out_valid(out_valid26), .out_ready(out_ready26),
    .out_data(out_data26), .out_row(out_row26), .out_col(out_col26), .out_last(out_last26)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rand16();
    logic signed [DW-1:0] v;
    v = DW'($urandom());
    return int'(v);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference model: every 2x2 block whose bottom-right pixel lies within the
  // first n_in raster pixels yields its max, in pooled raster order.
  task automatic model(input int inst, input int rows, input int cols, input int n_in);
    int m, br;
    logic [EW-1:0] e;
    for (int i = 0; i < rows / 2; i++) begin
      for (int j = 0; j < cols / 2; j++) begin
        br = (2 * i + 1) * cols + 2 * j + 1;
        if (br < n_in) begin
          m = max4(pix[2*i*cols + 2*j], pix[2*i*cols + 2*j + 1],
                   pix[(2*i+1)*cols + 2*j], pix[(2*i+1)*cols + 2*j + 1]);
          e = {(i == rows / 2 - 1) && (j == cols / 2 - 1), CW'(i), CW'(j), DW'(m)};
          if (inst == 0) exp4_q.push_back(e);
          else exp26_q.push_back(e);
        end
      end
    end
  endtask

  // Drive one pixel; returns at posedge+1 after the edge that accepted it.
  task automatic push_pix(input int inst, input int v, input bit gaps);
    bit ok, rdy;
    if (gaps && ($urandom_range(0, 2) == 0)) begin
      if (inst == 0) in_valid4 = 1'b0; else in_valid26 = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    if (inst == 0) begin in_valid4 = 1'b1; in_data4 = DW'(v); end
    else begin in_valid26 = 1'b1; in_data26 = DW'(v); end
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk);
      rdy = (inst == 0) ? in_ready4 : in_ready26;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (inst == 0) in_valid4 = 1'b0; else in_valid26 = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL in_accept_timeout: inst %0d got no accept expected accept", inst);
    end
  endtask

  task automatic drive_frame(input int inst, input int n_in, input bit gaps);
    for (int i = 0; i < n_in; i++) push_pix(inst, pix[i], gaps);
  endtask

  task automatic drain(input int inst);
    for (int t = 0; t < 3000; t++) begin
      if (((inst == 0) ? exp4_q.size() : exp26_q.size()) == 0) break;
      @(posedge clk); #1;
    end
    check((inst == 0) ? "drain4" : "drain26", (inst == 0) ? exp4_q.size() : exp26_q.size(), 0);
  endtask

  // Monitor: pops on each output transfer; also checks outputs stay frozen
  // while the consumer stalls.
  task automatic mon_step(input int inst);
    logic ov, ordy, cl;
    logic [EW-1:0] f, e;
    ov   = (inst == 0) ? out_valid4 : out_valid26;
    ordy = (inst == 0) ? out_ready4 : out_ready26;
    cl   = (inst == 0) ? clr4 : clr26;
    f    = (inst == 0) ? {out_last4, out_row4, out_col4, out_data4}
                       : {out_last26, out_row26, out_col26, out_data26};
    if (prev_hold[inst]) check("hold_stable", {ov, f}, {1'b1, prev_f[inst]});
    if (ov && ordy) begin
      if (((inst == 0) ? exp4_q.size() : exp26_q.size()) == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out_unexpected: inst %0d got output %0h expected none", inst, f);
      end else begin
        e = (inst == 0) ? exp4_q.pop_front() : exp26_q.pop_front();
        check((inst == 0) ? "out_beat4" : "out_beat26", f, e);
      end
    end
    prev_hold[inst] = ov && !ordy && !cl && !rst;
    prev_f[inst]    = f;
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int m;
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid4", out_valid4, 0);
    check("rst_last4", out_last4, 0);
    check("rst_fields4", {out_row4, out_col4, out_data4}, 0);
    check("rst_fields26", {out_valid26, out_last26, out_row26, out_col26, out_data26}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready4", in_ready4, 1);
    check("rst_in_ready26", in_ready26, 1);

    // ---------------- 4x4 ramp, one-cycle latency ----------------
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = i;
    model(0, 4, 4, 16);
    for (int i = 0; i < 16; i++) begin
      push_pix(0, pix[i], 1'b0);
      check("ramp_valid", out_valid4, ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1));
      check("ramp_last", out_last4, i == 15);
    end
    drain(0);

    // ---------------- 4x4 signed ----------------
    for (int i = 0; i < 16; i++) pix[i] = -100 + i;
    model(0, 4, 4, 16);
    drive_frame(0, 16, 1'b1);
    drain(0);

    // ---------------- 4x4 backpressure ----------------
    out_ready4 = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = rand16();
    model(0, 4, 4, 16);
    fork
      drive_frame(0, 16, 1'b0);
      begin
        for (int t = 0; t < 100; t++) begin
          if (out_valid4) break;
          @(posedge clk); #1;
        end
        check("bp_valid_seen", out_valid4, 1);
        repeat (8) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready4, 0);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
      end
    join
    drain(0);

    // ---------------- 4x4 clr with pending output ----------------
    out_ready4 = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = rand16();
    for (int i = 0; i < 6; i++) push_pix(0, pix[i], 1'b0);
    m = max4(pix[0], pix[1], pix[4], pix[5]);
    in_valid4 = 1'b1;
    in_data4  = 16'sd777;
    clr4      = 1'b1;
    @(negedge clk);
    check("clr_pending_valid", out_valid4, 1);
    check("clr_pending_data", out_data4, DW'(m));
    check("clr_in_ready", in_ready4, 0);
    @(posedge clk); #1;
    clr4 = 1'b0;
    in_valid4 = 1'b0;
    check("clr_valid_low", out_valid4, 0);
    check("clr_last_low", out_last4, 0);
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = rand16();
    model(0, 4, 4, 16);
    drive_frame(0, 16, 1'b1);
    drain(0);

    // ---------------- 26x26 two back-to-back random frames ----------------
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < 676; i++) pix[i] = rand16();
          model(1, 26, 26, 676);
          drive_frame(1, 676, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready26 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready26 = 1'b1;
    drain(1);

    // ---------------- 26x26 reset mid-frame ----------------
    for (int i = 0; i < 676; i++) pix[i] = rand16();
    model(1, 26, 26, 40);
    drive_frame(1, 40, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_partial_done", exp26_q.size(), 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid26, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 676; i++) pix[i] = rand16();
    model(1, 26, 26, 676);
    drive_frame(1, 676, 1'b1);
    drain(1);
    check("final_q4", exp4_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
